// File: rtl/fc_score_loader.sv
`default_nettype none
// ============================================================================
//  Module   : fc_score_loader
//  Brief    : Collects N class scores from a valid/ready stream into a flat
//             score array, sequences the argmax comparator (reset pulse,
//             enable, wait for done or watchdog), and emits the winning class
//             index as a one-cycle strobe.
//  Revision : 1.0 - initial release
// ============================================================================
module fc_score_loader #(
  parameter int N       = 10,
  parameter int DATA_W  = 16,
  parameter int IDX_W   = 4,
  parameter int TIMEOUT = 1024
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_data,
  output logic                in_ready,
  output logic [N*DATA_W-1:0] arr_flat,
  output logic                cmp_reset,
  output logic                cmp_enable,
  input  logic                cmp_done,
  input  logic [IDX_W-1:0]    cmp_result,
  output logic                class_valid,
  output logic [IDX_W-1:0]    class_id,
  output logic                busy,
  output logic                timeout_err
);

  // Three-state frame sequencer: gather words, pulse comparator reset, run.
  localparam logic [1:0] ST_COLLECT = 2'd0;
  localparam logic [1:0] ST_CLEAR   = 2'd1;
  localparam logic [1:0] ST_RUN     = 2'd2;

  // Watchdog only needs to reach TIMEOUT-1.
  localparam int               WD_W     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [WD_W-1:0]  WD_LAST  = WD_W'(TIMEOUT - 1);
  localparam logic [IDX_W-1:0] CNT_LAST = IDX_W'(N - 1);

  logic [1:0]       state;
  logic [1:0]       state_next;
  logic [IDX_W-1:0] cnt;
  logic [WD_W-1:0]  wd;
  logic             accept;
  logic             wd_expired;

  assign accept     = in_valid && in_ready;
  assign wd_expired = (wd == WD_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= ST_COLLECT;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode; a done seen on the watchdog's last cycle still wins.
  always_comb begin
    state_next = state;
    case (state)
      ST_COLLECT: begin
        if (accept && (cnt == CNT_LAST)) begin
          state_next = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        state_next = ST_RUN;
      end
      ST_RUN: begin
        if (cmp_done || wd_expired) begin
          state_next = ST_COLLECT;
        end
      end
      default: begin
        state_next = ST_COLLECT;
      end
    endcase
  end

  // Output decode; reset forces the idle/handshake-closed view immediately.
  always_comb begin
    in_ready   = 1'b0;
    cmp_reset  = reset;
    cmp_enable = 1'b0;
    busy       = 1'b0;
    if (!reset) begin
      case (state)
        ST_COLLECT: begin
          in_ready = 1'b1;
        end
        ST_CLEAR: begin
          cmp_reset = 1'b1;
          busy      = 1'b1;
        end
        ST_RUN: begin
          cmp_enable = 1'b1;
          busy       = 1'b1;
        end
        default: begin
          in_ready = 1'b0;
        end
      endcase
    end
  end

  // Word counter: restarts at entry 0 after the last word or on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt <= '0;
    end else if (accept) begin
      if (cnt == CNT_LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Score array: each entry only loads on an accepted word addressed to it.
  generate
    for (genvar i = 0; i < N; i++) begin : g_entry
      logic [DATA_W-1:0] entry;

      // Per-entry write.
      always_ff @(posedge clk) begin
        if (reset) begin
          entry <= '0;
        end else if (accept && (cnt == IDX_W'(i))) begin
          entry <= in_data;
        end
      end

      assign arr_flat[i*DATA_W +: DATA_W] = entry;
    end
  endgenerate

  // Watchdog: cleared in CLEAR so the first RUN cycle counts from zero.
  always_ff @(posedge clk) begin
    if (reset) begin
      wd <= '0;
    end else if (state == ST_CLEAR) begin
      wd <= '0;
    end else if (state == ST_RUN) begin
      wd <= wd + 1'b1;
    end
  end

  // Result capture, one-cycle strobe and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      class_valid <= 1'b0;
      class_id    <= '0;
      timeout_err <= 1'b0;
    end else begin
      class_valid <= 1'b0;
      if (state == ST_RUN) begin
        if (cmp_done) begin
          class_valid <= 1'b1;
          class_id    <= cmp_result;
        end else if (wd_expired) begin
          timeout_err <= 1'b1;
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fc_score_loader.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fc_score_loader
//  Brief    : Directed self-checking bench for fc_score_loader with a small
//             behavioural argmax comparator.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_fc_score_loader;

  localparam int N  = 10;
  localparam int DW = 16;
  localparam int IW = 4;
  localparam int AW = N * DW;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic [DW-1:0] in_data;
  logic          in_ready;
  logic [AW-1:0] arr_flat;
  logic          cmp_reset;
  logic          cmp_enable;
  logic          cmp_done;
  logic [IW-1:0] cmp_result;
  logic          class_valid;
  logic [IW-1:0] class_id;
  logic          busy;
  logic          timeout_err;

  fc_score_loader #(.N(N), .DATA_W(DW), .IDX_W(IW), .TIMEOUT(16)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_data     (in_data),
    .in_ready    (in_ready),
    .arr_flat    (arr_flat),
    .cmp_reset   (cmp_reset),
    .cmp_enable  (cmp_enable),
    .cmp_done    (cmp_done),
    .cmp_result  (cmp_result),
    .class_valid (class_valid),
    .class_id    (class_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [AW-1:0] got, input logic [AW-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural comparator: done after 3 enabled cycles, first maximum wins.
  bit model_on = 1'b1;
  int en_cnt   = 0;
  always @(negedge clk) begin
    logic [DW-1:0] best;
    int            bi;
    if (cmp_reset) en_cnt = 0;
    else if (cmp_enable) en_cnt++;
    best = arr_flat[DW-1:0];
    bi   = 0;
    for (int i = 1; i < N; i++) begin
      if (arr_flat[i*DW +: DW] > best) begin
        best = arr_flat[i*DW +: DW];
        bi   = i;
      end
    end
    cmp_result = IW'(bi);
    cmp_done   = model_on && cmp_enable && (en_cnt >= 3);
  end

  function automatic logic [AW-1:0] pack(input logic [DW-1:0] v[N]);
    logic [AW-1:0] r;
    for (int i = 0; i < N; i++) r[i*DW +: DW] = v[i];
    return r;
  endfunction

  // Stream results.
  int s_it, s_k, s_busy;
  task automatic send_frame(input logic [DW-1:0] v[N], input int n, input bit gap);
    int k  = 0;
    int it = 0;
    s_busy = 0;
    while (k < n && it < 200) begin
      @(negedge clk);
      if (gap && (it % 2 == 1)) in_valid = 1'b0;
      else begin
        in_valid = 1'b1;
        in_data  = v[k];
      end
      #1;
      if (busy) s_busy++;
      if (in_valid && in_ready) k++;
      it++;
    end
    s_it = it;
    s_k  = k;
  endtask

  // Result-wait observations.
  int            w_clr, w_first_clr, w_first_en, w_en, w_rdy_busy, w_chg;
  bit            w_got, w_rdy;
  logic [IW-1:0] w_id;
  logic [AW-1:0] w_snap;
  task automatic wait_result(input bit hold);
    int cyc = 0;
    bit done = 1'b0;
    w_clr = 0; w_first_clr = -1; w_first_en = -1; w_en = 0;
    w_rdy_busy = 0; w_chg = 0; w_got = 1'b0; w_rdy = 1'b0; w_id = '0;
    w_snap = '0;
    while (!done && cyc < 100) begin
      @(negedge clk);
      in_valid = hold;
      in_data  = 16'hFFFF;
      #1;
      if (cyc == 0) w_snap = arr_flat;
      if (class_valid) begin
        w_got = 1'b1;
        w_id  = class_id;
        w_rdy = in_ready;
        done  = 1'b1;
      end else if (w_en > 0 && !busy) begin
        done = 1'b1;
      end else begin
        if (cmp_reset) begin
          w_clr++;
          if (w_first_clr < 0) w_first_clr = cyc;
        end
        if (cmp_enable) begin
          w_en++;
          if (w_first_en < 0) w_first_en = cyc;
        end
        if (in_ready) w_rdy_busy++;
        if (arr_flat !== w_snap) w_chg++;
      end
      cyc++;
    end
  endtask

  logic [DW-1:0] v1 [N] = '{16'h0800, 16'h0000, 16'h0001, 16'h0002, 16'h0004,
                            16'h0008, 16'h0010, 16'h0020, 16'h0040, 16'h0080};
  logic [DW-1:0] vff[N] = '{default: 16'hFFFF};
  logic [DW-1:0] v5 [N] = '{16'h0010, 16'h0020, 16'h0030, 16'h0040, 16'h0050,
                            16'h0060, 16'h0070, 16'h7000, 16'h0090, 16'h00A0};
  logic [DW-1:0] v6a[N] = '{16'h0100, 16'h0101, 16'h0102, 16'h9000, 16'h0104,
                            16'h0105, 16'h0106, 16'h0107, 16'h0108, 16'h0109};
  logic [DW-1:0] v6b[N] = '{16'h0050, 16'h0050, 16'h0050, 16'h0050, 16'h0050,
                            16'h0050, 16'h0050, 16'h0050, 16'h0050, 16'hA000};

  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1, "bench timed out");
  end

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;

    // Reset values.
    repeat (5) @(negedge clk);
    #1;
    check("rst_in_ready",    AW'(in_ready),    AW'(0));
    check("rst_cmp_reset",   AW'(cmp_reset),   AW'(1));
    check("rst_cmp_enable",  AW'(cmp_enable),  AW'(0));
    check("rst_busy",        AW'(busy),        AW'(0));
    check("rst_class_valid", AW'(class_valid), AW'(0));
    check("rst_class_id",    AW'(class_id),    AW'(0));
    check("rst_timeout_err", AW'(timeout_err), AW'(0));
    check("rst_arr",         arr_flat,         AW'(0));
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("post_rst_in_ready", AW'(in_ready), AW'(1));

    // 1: continuous stream.
    send_frame(v1, N, 1'b0);
    check("t1_no_bubbles", AW'(s_it), AW'(N));
    wait_result(1'b0);
    check("t1_entry0", AW'(w_snap[15:0]),    AW'(16'h0800));
    check("t1_entry9", AW'(w_snap[159:144]), AW'(16'h0080));
    check("t1_clr_cycles", AW'(w_clr),       AW'(1));
    check("t1_clr_first",  AW'(w_first_clr), AW'(0));
    check("t1_en_first",   AW'(w_first_en),  AW'(1));
    check("t1_got",        AW'(w_got),       AW'(1));
    check("t1_class_id",   AW'(w_id),        AW'(0));
    check("t1_ready_at_cv", AW'(w_rdy),      AW'(1));
    @(negedge clk); #1;
    check("t1_cv_one_cycle", AW'(class_valid), AW'(0));

    // 2: in_valid toggling.
    send_frame(v1, N, 1'b1);
    check("t2_gaps_taken", AW'(s_it), AW'(2 * N - 1));
    check("t2_busy_early", AW'(s_busy), AW'(0));
    wait_result(1'b0);
    check("t2_array", w_snap, pack(v1));
    check("t2_clr_first", AW'(w_first_clr), AW'(0));
    check("t2_class_id", AW'(w_id), AW'(0));

    // 3: in_valid with 0xFFFF held through CLEAR/RUN.
    send_frame(v6a, N, 1'b0);
    wait_result(1'b1);
    check("t3_ready_busy", AW'(w_rdy_busy), AW'(0));
    check("t3_arr_stable", AW'(w_chg),      AW'(0));
    check("t3_arr_before", w_snap,          pack(v6a));
    check("t3_class_id",   AW'(w_id),       AW'(3));
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    check("t3_ff_entry0", AW'(arr_flat[15:0]), AW'(16'hFFFF));
    check("t3_entry1_old", AW'(arr_flat[31:16]), AW'(16'h0101));
    send_frame(vff, N - 1, 1'b0);
    wait_result(1'b0);
    check("t3_ff_frame", w_snap, pack(vff));
    check("t3_ff_class", AW'(w_id), AW'(0));

    // 4: comparator never finishes.
    model_on = 1'b0;
    send_frame(v1, N, 1'b0);
    wait_result(1'b0);
    check("t4_run_cycles",   AW'(w_en),        AW'(16));
    check("t4_no_cv",        AW'(w_got),       AW'(0));
    check("t4_timeout_err",  AW'(timeout_err), AW'(1));
    check("t4_back_collect", AW'(in_ready),    AW'(1));
    model_on = 1'b1;
    repeat (5) @(negedge clk);
    #1;
    check("t4_sticky", AW'(timeout_err), AW'(1));

    // 5: reset mid-frame.
    send_frame(v5, 6, 1'b0);
    @(negedge clk);
    in_valid = 1'b0;
    reset    = 1'b1;
    @(negedge clk); #1;
    check("t5_rst_in_ready",  AW'(in_ready),    AW'(0));
    check("t5_rst_cmp_reset", AW'(cmp_reset),   AW'(1));
    check("t5_rst_timeout",   AW'(timeout_err), AW'(0));
    check("t5_rst_arr",       arr_flat,         AW'(0));
    check("t5_rst_busy",      AW'(busy),        AW'(0));
    @(negedge clk);
    reset = 1'b0;
    send_frame(v5, N, 1'b0);
    wait_result(1'b0);
    check("t5_array",    w_snap, pack(v5));
    check("t5_class_id", AW'(w_id), AW'(7));

    // 6: back-to-back frames.
    send_frame(v6a, N, 1'b0);
    wait_result(1'b0);
    check("t6_first_id", AW'(w_id), AW'(3));
    send_frame(v6b, N, 1'b0);
    check("t6_hold_id", AW'(class_id), AW'(3));
    check("t6_hold_cv", AW'(class_valid), AW'(0));
    wait_result(1'b0);
    check("t6_second_got", AW'(w_got), AW'(1));
    check("t6_second_id",  AW'(w_id),  AW'(9));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
